line_arbiter: RTL and testbench

Round-robin arbiter that shares one line-drawing engine between NREQ drawing clients. Each client presents a line request with its endpoint coordinates. The arbiter grants one request at a time, latches the coordinates and pulses the engine's start. It waits for the engine's done, then returns a per-client completion pulse. A watchdog aborts the engine if a line never completes, so a hung line cannot lock out the other clients. It sits between the shape/sprite generators and the single line engine feeding the framebuffer.

---
 rtl/line_arbiter.sv | 117 +++++++++++
 tb/tb_line_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/line_arbiter.sv
// line_arbiter: round-robin arbiter sharing one line engine among NREQ clients, with watchdog abort
// Ports: clk/rst (async, active-high); req + req_x0/y0/x1/y1 per-client requests and coordinates;
// oe pixel-writer enable; line_done engine completion. Outputs: ack/req_done/req_err per-client pulses,
// busy, gnt_id, line_start/line_abort engine pulses, line_x0/y0/x1/y1 latched coordinates, line_oe.
module line_arbiter #(
  parameter int NREQ    = 4,
  parameter int CORDW   = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CORDW-1:0]    req_x0,
  input  logic [NREQ*CORDW-1:0]    req_y0,
  input  logic [NREQ*CORDW-1:0]    req_x1,
  input  logic [NREQ*CORDW-1:0]    req_y1,
  input  logic                     oe,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          req_done,
  output logic [NREQ-1:0]          req_err,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     line_start,
  output logic [CORDW-1:0]         line_x0,
  output logic [CORDW-1:0]         line_y0,
  output logic [CORDW-1:0]         line_x1,
  output logic [CORDW-1:0]         line_y1,
  output logic                     line_oe,
  output logic                     line_abort,
  input  logic                     line_done
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ABORT} state_t;
  state_t            r_state;
  logic [IW-1:0]     r_ptr, r_gnt, w_win, w_nxt;
  logic [CW-1:0]     r_cnt;
  logic [NREQ-1:0]   r_ack, r_done, r_err, w_gnt_oh;
  logic              r_busy, r_start, r_abort;
  logic [CORDW-1:0]  r_x0, r_y0, r_x1, r_y1;
  // descending scan so the requester closest above ptr is the last (winning) assignment
  always_comb begin
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(r_ptr) + k) % NREQ]) w_win = IW'((int'(r_ptr) + k) % NREQ);
  end
  assign w_nxt    = (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
  assign w_gnt_oh = NREQ'(1) << r_gnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
    end else begin
      r_ack   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: if (|req) begin
          r_ack   <= NREQ'(1) << w_win;
          r_x0    <= req_x0[w_win*CORDW +: CORDW];
          r_y0    <= req_y0[w_win*CORDW +: CORDW];
          r_x1    <= req_x1[w_win*CORDW +: CORDW];
          r_y1    <= req_y1[w_win*CORDW +: CORDW];
          r_gnt   <= w_win;
          r_busy  <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_start <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (line_done) begin
          r_done  <= w_gnt_oh;
          r_busy  <= 1'b0;
          r_ptr   <= w_nxt;
          r_state <= S_IDLE;
        end else if (oe) begin
          // abort pulses are registered on entry so they are visible during ABORT
          if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_err   <= w_gnt_oh;
            r_abort <= 1'b1;
            r_busy  <= 1'b0;
            r_ptr   <= w_nxt;
            r_state <= S_ABORT;
          end else r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  assign ack        = r_ack;
  assign req_done   = r_done;
  assign req_err    = r_err;
  assign busy       = r_busy;
  assign gnt_id     = r_gnt;
  assign line_start = r_start;
  assign line_abort = r_abort;
  assign line_x0    = r_x0;
  assign line_y0    = r_y0;
  assign line_x1    = r_x1;
  assign line_y1    = r_y1;
  assign line_oe    = oe & r_busy;
endmodule

// File: tb/tb_line_arbiter.sv
// tb_line_arbiter: self-checking bench for line_arbiter (directed tables, corner sequences, random vs model)
module tb_line_arbiter;
  localparam int N = 4, CW = 10, TO = 8;
  logic clk = 1'b0, rst = 1'b1, oe = 1'b0, line_done = 1'b0;
  logic [N-1:0] req = '0;
  logic [CW-1:0] cx0[N], cy0[N], cx1[N], cy1[N];
  logic [N*CW-1:0] req_x0, req_y0, req_x1, req_y1;
  logic [N-1:0] ack, req_done, req_err;
  logic busy, line_start, line_oe, line_abort;
  logic [1:0] gnt_id;
  logic [CW-1:0] line_x0, line_y0, line_x1, line_y1;
  logic [57:0] all_o;
  int total = 0, bad = 0;
  typedef struct {
    logic [N-1:0] rq;
    logic oe, dn;
    logic [N-1:0] ack, rd;
    logic bsy, st, lo;
    logic [1:0] gnt;
  } vec_t;
  vec_t tv[5];
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_x0[g*CW +: CW] = cx0[g];
    assign req_y0[g*CW +: CW] = cy0[g];
    assign req_x1[g*CW +: CW] = cx1[g];
    assign req_y1[g*CW +: CW] = cy1[g];
  end
  assign all_o = {ack, req_done, req_err, busy, gnt_id, line_start, line_x0, line_y0, line_x1, line_y1,
                  line_oe, line_abort};
  line_arbiter #(.NREQ(N), .CORDW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .oe(oe), .ack(ack), .req_done(req_done), .req_err(req_err), .busy(busy), .gnt_id(gnt_id),
    .line_start(line_start), .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
    .line_oe(line_oe), .line_abort(line_abort), .line_done(line_done)
  );
  task automatic step;
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1; req = '0; oe = 1'b0; line_done = 1'b0;
    step; step;
    rst = 1'b0;
  endtask
  task automatic rnd_coord(input int i);
    cx0[i] = CW'($urandom); cy0[i] = CW'($urandom); cx1[i] = CW'($urandom); cy1[i] = CW'($urandom);
  endtask
  task automatic serve(input int exp, input int dly, input logic [N-1:0] nxt);
    step;
    chk("s_ack", ack, 64'(1) << exp); chk("s_gnt", gnt_id, exp);
    req = nxt;
    step;
    chk("s_start", line_start, 1); chk("s_ack_width", ack, 0);
    repeat (dly) step;
    line_done = 1'b1;
    step;
    line_done = 1'b0;
    chk("s_done", req_done, 64'(1) << exp); chk("s_done_gnt", gnt_id, exp); chk("s_busy", busy, 0);
  endtask
  task automatic rand_phase(input int lines);
    int mptr = 0, win, n, dly;
    bit hang, res;
    for (int l = 0; l < lines; l++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(1, 0) == 1) begin req[i] = 1'b1; rnd_coord(i); end
      if (req == '0) begin win = int'($urandom_range(N - 1, 0)); req[win] = 1'b1; rnd_coord(win); end
      win = 0;
      for (int k = N - 1; k >= 0; k--) if (req[(mptr + k) % N]) win = (mptr + k) % N;
      step;
      chk("r_ack", ack, 64'(1) << win); chk("r_gnt", gnt_id, win);
      chk("r_coord", {line_x0, line_y0, line_x1, line_y1}, {cx0[win], cy0[win], cx1[win], cy1[win]});
      if ($urandom_range(1, 0) == 1) rnd_coord(win); else req[win] = 1'b0;
      step;
      chk("r_start", line_start, 1);
      hang = $urandom_range(3, 0) == 0; dly = int'($urandom_range(10, 0)); n = 0; res = 1'b0;
      for (int c = 0; c < 200 && !res; c++) begin
        oe = 1'($urandom_range(1, 0)); line_done = !hang && c == dly;
        step;
        if (line_done) begin
          chk("r_done", {req_done, req_err, line_abort}, {4'(1 << win), 4'b0, 1'b0}); res = 1'b1;
        end else begin
          if (oe) n++;
          if (n == TO) begin
            chk("r_err", {req_err, line_abort, req_done}, {4'(1 << win), 1'b1, 4'b0}); res = 1'b1;
            oe = 1'b0;
            step;
            chk("r_holdoff", ack, 0);
          end else chk("r_quiet", {req_done, req_err, line_abort}, 0);
        end
      end
      line_done = 1'b0; oe = 1'b0;
      chk("r_resolved", res, 1);
      mptr = (win + 1) % N;
    end
  endtask
  initial begin
    int n, early, acks;
    for (int i = 0; i < N; i++) begin
      cx0[i] = CW'(100 + i); cy0[i] = CW'(200 + i); cx1[i] = CW'(300 + i); cy1[i] = CW'(400 + i);
    end
    cx0[2] = 10'd10; cy0[2] = 10'd20; cx1[2] = 10'd30; cy1[2] = 10'd5;
    tv[0] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2};
    tv[1] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2};
    tv[2] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2};
    tv[3] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd2};
    tv[4] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2};
    step;
    chk("reset_state", all_o, 0);
    rst = 1'b0;
    line_done = 1'b1;
    step;
    line_done = 1'b0;
    chk("idle_done_ignored", {req_done, busy}, 0);
    for (int r = 0; r < 5; r++) begin
      req = tv[r].rq; oe = tv[r].oe; line_done = tv[r].dn;
      step;
      chk($sformatf("t%0d_ack", r), ack, tv[r].ack);
      chk($sformatf("t%0d_done", r), req_done, tv[r].rd);
      chk($sformatf("t%0d_busy", r), busy, tv[r].bsy);
      chk($sformatf("t%0d_start", r), line_start, tv[r].st);
      chk($sformatf("t%0d_oe", r), line_oe, tv[r].lo);
      chk($sformatf("t%0d_gnt", r), gnt_id, tv[r].gnt);
    end
    req = '0; oe = 1'b0; line_done = 1'b0;
    chk("single_coords", {line_x0, line_y0, line_x1, line_y1}, {10'd10, 10'd20, 10'd30, 10'd5});
    do_reset;
    req = 4'hf;
    serve(0, 1, 4'hf); serve(1, 2, 4'hf); serve(2, 0, 4'hf); serve(3, 1, 4'hf); serve(0, 0, 4'h0);
    do_reset;
    req = 4'b0010;
    serve(1, 0, 4'b0000);
    req = 4'b1001;
    serve(3, 0, 4'b0001);
    serve(0, 0, 4'b0000);
    do_reset;
    req = 4'b0010;
    step;
    chk("wd_ack", ack, 4'b0010);
    req = '0; line_done = 1'b1;
    step;
    line_done = 1'b0;
    chk("issue_done_ignored", req_done, 0); chk("wd_start", line_start, 1);
    n = 0; early = 0;
    for (int c = 0; c < 40 && n < TO; c++) begin
      oe = (c % 3 != 2);
      step;
      if (oe) n++;
      if (n < TO) early += int'(req_err != 0 || line_abort || line_oe !== oe || !busy);
    end
    chk("wd_early", early, 0); chk("wd_count", n, TO);
    chk("wd_err", req_err, 4'b0010); chk("wd_abort", line_abort, 1); chk("wd_busy", busy, 0);
    oe = 1'b0;
    step;
    chk("wd_pulse", {req_err, line_abort}, 0);
    req = 4'b0100;
    step;
    chk("wd_next_ack", ack, 4'b0100);
    req = '0;
    step;
    early = 0;
    repeat (TO - 1) begin
      oe = 1'b1;
      step;
      early += int'(req_err != 0 || line_abort || req_done != 0);
    end
    chk("tie_early", early, 0);
    line_done = 1'b1;
    step;
    line_done = 1'b0; oe = 1'b0;
    chk("tie_done", {req_done, req_err, line_abort}, {4'b0100, 4'b0, 1'b0});
    do_reset;
    req = 4'b0001;
    step;
    chk("wd_req_ack", ack, 4'b0001);
    req = '0;
    step;
    req = 4'b0010;
    step;
    req = '0; line_done = 1'b1;
    step;
    line_done = 1'b0;
    chk("wd_req_done", req_done, 4'b0001);
    acks = 0;
    repeat (6) begin step; acks += int'(ack != 0); end
    chk("withdrawn", acks, 0);
    do_reset;
    req = 4'b1000;
    step;
    chk("mr_ack", ack, 4'b1000);
    req = 4'hf;
    step;
    oe = 1'b1;
    step; step;
    #2 rst = 1'b1;
    #1 chk("async_reset", all_o, 0);
    step;
    chk("reset_no_abort", all_o, 0);
    rst = 1'b0;
    step;
    chk("mr_first", ack, 4'b0001);
    do_reset;
    rand_phase(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
